// File: rtl/fx_kpad_pkg.sv
// Shared constants, FSM state type and pad-word packing for the PC-FX K-port pad responder.
package fx_kpad_pkg;

    localparam int KP_WORD_BITS = 32;
    localparam int NUM_BTNS     = 14;

    localparam logic [3:0] PAD_ID_STD = 4'hF;

    localparam int BTN_I      = 0;
    localparam int BTN_II     = 1;
    localparam int BTN_III    = 2;
    localparam int BTN_IV     = 3;
    localparam int BTN_V      = 4;
    localparam int BTN_VI     = 5;
    localparam int BTN_SELECT = 6;
    localparam int BTN_RUN    = 7;
    localparam int BTN_UP     = 8;
    localparam int BTN_RIGHT  = 9;
    localparam int BTN_DOWN   = 10;
    localparam int BTN_LEFT   = 11;
    localparam int BTN_MODE1  = 12;
    localparam int BTN_MODE2  = 13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } kp_state_e;

    // ID in the top nibble, buttons in the low 14 bits, everything between reads 0.
    function automatic logic [KP_WORD_BITS-1:0] pad_word(input logic [3:0]          id,
                                                         input logic [NUM_BTNS-1:0] btn);
        return {id, 14'b0, btn};
    endfunction

endpackage

// File: rtl/fx_kpad_turbo.sv
// Turbo phase generator for buttons I/II: counts latch entries and toggles a phase every TURBO_DIV entries.
// Zero latency on the mask; phase/counter update on the entry cycle, and the mask already reflects that update.
module fx_kpad_turbo
    import fx_kpad_pkg::*;
#(
    parameter int TURBO_DIV = 4
) (
    input  logic       clk,
    input  logic       res,
    input  logic       ce,
    input  logic       entry,
    input  logic [1:0] turbo,
    input  logic [1:0] btn,
    output logic [1:0] btn_masked
);

    logic [7:0] cnt;
    logic       phase;
    logic       wrap;
    logic       phase_next;
    logic       phase_eff;

    // Counter runs 1..TURBO_DIV after the first entry; the phase flips on the entry that finds it full.
    always_comb begin
        wrap       = (cnt == 8'(TURBO_DIV));
        phase_next = wrap ? ~phase : phase;
        phase_eff  = entry ? phase_next : phase;
        btn_masked = btn;
        if (turbo[BTN_I])  btn_masked[BTN_I]  = btn[BTN_I]  & phase_eff;
        if (turbo[BTN_II]) btn_masked[BTN_II] = btn[BTN_II] & phase_eff;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            cnt   <= 8'd0;
            phase <= 1'b1;
        end else if (ce && entry) begin
            cnt   <= wrap ? 8'd1 : cnt + 8'd1;
            phase <= phase_next;
        end
    end

endmodule

// File: rtl/fx_kpad_port.sv
// PC-FX K-port pad responder: latches a 32-bit pad word, shifts it out LSB-first on KP_SCK while shifting KP_DI in.
// KP_DO is registered (one CE cycle after the causing sample); host fully paces the transfer. Optional turbo via FX_KPAD_TURBO_EN.
module fx_kpad_port
    import fx_kpad_pkg::*;
#(
    parameter logic [3:0] PAD_ID    = PAD_ID_STD,
    parameter int          TURBO_DIV = 4
) (
    input  logic                    CLK,
    input  logic                    RES,
    input  logic                    CE,
    input  logic                    KP_LATCH,
    input  logic                    KP_SCK,
    input  logic                    KP_DI,
    output logic                    KP_DO,
    input  logic [NUM_BTNS-1:0]     BUTTONS,
    input  logic [1:0]              TURBO,
    output logic [KP_WORD_BITS-1:0] RX_DATA,
    output logic                    RX_VALID,
    output logic                    BUSY
);

    kp_state_e               state;
    kp_state_e               state_next;
    logic [KP_WORD_BITS-1:0] tx_sr;
    logic [KP_WORD_BITS-1:0] rx_sr;
    logic [5:0]              cnt;
    logic                    sck_q;
    logic                    sck_rise;
    logic                    last_bit;
    logic                    kp_do;
    logic [KP_WORD_BITS-1:0] rx_data;
    logic                    rx_valid;
    logic [NUM_BTNS-1:0]     btn_eff;

    assign sck_rise = KP_SCK & ~sck_q;
    assign last_bit = (state == SHIFT) && sck_rise && (cnt == 6'd31);

`ifdef FX_KPAD_TURBO_EN
    logic       entry;
    logic [1:0] btn_lo;

    assign entry = KP_LATCH && ((state == IDLE) || (state == DONE));

    fx_kpad_turbo #(
        .TURBO_DIV (TURBO_DIV)
    ) u_turbo (
        .clk        (CLK),
        .res        (RES),
        .ce         (CE),
        .entry      (entry),
        .turbo      (TURBO),
        .btn        (BUTTONS[1:0]),
        .btn_masked (btn_lo)
    );

    assign btn_eff = {BUTTONS[NUM_BTNS-1:2], btn_lo};
`else
    logic [1:0] unused_turbo;

    assign unused_turbo = TURBO ^ 2'(TURBO_DIV);
    assign btn_eff      = BUTTONS;
`endif

    always_ff @(posedge CLK) begin
        if (RES) begin
            state <= IDLE;
        end else if (CE) begin
            state <= state_next;
        end
    end

    // A latch strobe restarts the transfer from any state and masks a coincident SCK edge.
    always_comb begin
        state_next = state;
        if (KP_LATCH) begin
            state_next = LOAD;
        end else begin
            case (state)
                LOAD:    state_next = SHIFT;
                SHIFT:   if (last_bit) state_next = DONE;
                default: state_next = state;
            endcase
        end
    end

    always_comb begin
        BUSY     = (state == LOAD) || (state == SHIFT);
        KP_DO    = kp_do;
        RX_DATA  = rx_data;
        RX_VALID = rx_valid;
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            tx_sr    <= '1;
            rx_sr    <= '0;
            cnt      <= 6'd0;
            sck_q    <= 1'b0;
            kp_do    <= 1'b1;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (CE) begin
                sck_q <= KP_SCK;
                if (KP_LATCH) begin
                    tx_sr <= pad_word(PAD_ID, btn_eff);
                    rx_sr <= '0;
                    cnt   <= 6'd0;
                    kp_do <= btn_eff[0];
                end else if ((state == SHIFT) && sck_rise) begin
                    tx_sr <= {1'b1, tx_sr[KP_WORD_BITS-1:1]};
                    rx_sr <= {KP_DI, rx_sr[KP_WORD_BITS-1:1]};
                    cnt   <= cnt + 6'd1;
                    kp_do <= tx_sr[1];
                    if (last_bit) begin
                        rx_data  <= {KP_DI, rx_sr[KP_WORD_BITS-1:1]};
                        rx_valid <= 1'b1;
                        kp_do    <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
